pipeline_control: RTL and testbench
===================================

# pipeline_control

Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It consumes decode-stage hazard and trap information, the EX-stage redirect and the data cache handshake. From these it drives per-stage enable and flush strobes. It also owns the RUN/DRAIN/HALTED state machine used for ECALL, EBREAK, illegal instructions and memory timeouts, plus cycle and stall performance counters.

## Interface
- DRAIN_CYCLES, 3, unfrozen cycles to retire instructions older than a trap (EX, MEM, WB).
- MEM_TIMEOUT, 255, max consecutive cycles of i_MEM_Req && !i_MEM_Ready before a bus-timeout trap.
- CNT_WIDTH, 32, width of performance counters.

Ports:
- i_Clock  in  1  sole clock; all state on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_ID_Valid  in  1  ID holds a real (non-bubble) instruction.
- i_ID_rs1, i_ID_rs2  in  5  ID source registers.
- i_ID_UsesRs1, i_ID_UsesRs2  in  1  source actually read.
- i_ID_EnvCall, i_ID_EnvBreak, i_ID_Illegal  in  1  decoder trap flags.
- i_EX_MemRead  in  1  EX instruction is a load.
- i_EX_rd  in  5  EX destination register.
- i_EX_Redirect  in  1  taken branch, JAL or JALR resolved in EX.
- i_MEM_Req  in  1  MEM stage has a load/store outstanding.
- i_MEM_Ready  in  1  data cache completes the access this cycle.
- i_Resume  in  1  leave HALTED (debug/testbench strobe).
- o_PC_Enable, o_IFID_Enable, o_IDEX_Enable, o_EXMEM_Enable, o_MEMWB_Enable  out  1  stage register update enables.
- o_IFID_Flush, o_IDEX_Flush  out  1  load a bubble instead of the upstream value.
- o_Halted  out  1  state == HALTED.
- o_TrapCause  out  3  0 none, 1 ECALL, 2 EBREAK, 3 ILLEGAL, 4 MEM_TIMEOUT.
- o_CycleCount, o_StallCount  out  CNT_WIDTH  performance counters.

## Operation
- States: RUN, DRAIN, HALTED. Registers: state, drain counter, wait counter, cause, two perf counters.
- Reset (i_Reset_n low, immediate): state RUN, counters 0, o_TrapCause 0, o_Halted 0. Output overrides while reset is low: all enables 0, both flushes 1.
- Freeze = i_MEM_Req && !i_MEM_Ready and state != HALTED. It has the highest priority:
  - All enables are 0 and both flushes are 0.
  - The drain counter holds. EX-stage inputs stay stable, so a pending redirect is acted on after the freeze.
- Wait counter:
  - Increments each frozen cycle and clears on any unfrozen cycle.
  - When it equals MEM_TIMEOUT and the cycle is still frozen, the next state is HALTED with cause 4.
  - If i_MEM_Ready is high in that same cycle, the access completes and no trap occurs.
- RUN, not frozen, priority order:
  1. Redirect: all enables 1, IFID and IDEX flushed. ID trap flags and load-use checks are ignored because ID holds a wrong-path instruction.
  2. Trap: i_ID_Valid with any trap flag. o_PC_Enable=0, IFID flushed, IDEX flushed so the trap instruction never enters EX. Next state DRAIN, drain counter = DRAIN_CYCLES. Cause encoding priority is ILLEGAL > EBREAK > ECALL.
  3. Load-use: i_ID_Valid && i_EX_MemRead && i_EX_rd != 0 && ((i_ID_UsesRs1 && rs1 == rd) || (i_ID_UsesRs2 && rs2 == rd)). PC and IFID enables 0, o_IDEX_Flush 1, EXMEM and MEMWB enables 1.
  4. Otherwise: all enables 1, no flushes.
- DRAIN, not frozen:
  - PC and IFID enables 0; IDEX flushed; EXMEM and MEMWB enabled.
  - i_EX_Redirect is ignored, since any redirecting instruction is younger than the trap.
  - Drain counter decrements; when it reaches 1, the next state is HALTED.
- HALTED: all enables 0, flushes 0, o_Halted 1, cause held. i_Resume moves to RUN the next cycle and clears the cause.
- o_CycleCount increments every cycle while state != HALTED and wraps modulo 2^CNT_WIDTH.
- o_StallCount increments every cycle with state != HALTED and o_PC_Enable == 0 (freeze, load-use, trap entry, DRAIN). It also wraps.

## Timing
- All outputs except the counters, o_Halted and o_TrapCause are combinational from the current state and inputs; the same-cycle response is required.
- Load-use inserts exactly one bubble; the dependent instruction re-checks the next cycle against a bubble in EX.
- Trap to o_Halted: DRAIN_CYCLES + 1 cycles (entry cycle plus DRAIN cycles), plus one cycle per frozen cycle during DRAIN.
- Memory timeout: o_Halted rises in the cycle after the MEM_TIMEOUT-th consecutive frozen cycle.
- Resume: RUN is active in the cycle after the i_Resume cycle.

## Test plan
- Load-use: EX lw x5 (i_EX_MemRead=1, rd=5); ID add with rs1=5, UsesRs1=1 -> one cycle of PC/IFID enable 0 and IDEX_Flush 1, then normal flow. Repeat with rd=0 -> no stall.
- Redirect with load-use and ECALL in ID in the same cycle -> IFID/IDEX flushed, PC enabled, no stall, state stays RUN, cause 0.
- ECALL with DRAIN_CYCLES=3, one freeze cycle mid-drain -> o_Halted high 5 cycles after entry with cause 1; i_Resume -> RUN the next cycle with cause 0.
- Memory timeout with MEM_TIMEOUT=4 and i_MEM_Ready held low -> HALTED, cause 4, after 4 frozen cycles. Rerun with Ready asserted on the 4th cycle -> no trap.
- Asynchronous reset pulsed mid-DRAIN, between clock edges -> immediate RUN, counters 0, enables 0 and flushes 1 while low.
- Illegal and EBREAK asserted together -> cause 3. Counters after 10 RUN cycles including one load-use stall -> o_CycleCount 10, o_StallCount 1.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Bundle of hazard/trap inputs and stage-control outputs for the pipeline controller.
// The master side is the controller; the slave side is the datapath that obeys it.
interface pipeline_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 i_ID_Valid;
  logic [4:0]           i_ID_rs1;
  logic [4:0]           i_ID_rs2;
  logic                 i_ID_UsesRs1;
  logic                 i_ID_UsesRs2;
  logic                 i_ID_EnvCall;
  logic                 i_ID_EnvBreak;
  logic                 i_ID_Illegal;
  logic                 i_EX_MemRead;
  logic [4:0]           i_EX_rd;
  logic                 i_EX_Redirect;
  logic                 i_MEM_Req;
  logic                 i_MEM_Ready;
  logic                 i_Resume;
  logic                 o_PC_Enable;
  logic                 o_IFID_Enable;
  logic                 o_IDEX_Enable;
  logic                 o_EXMEM_Enable;
  logic                 o_MEMWB_Enable;
  logic                 o_IFID_Flush;
  logic                 o_IDEX_Flush;
  logic                 o_Halted;
  logic [2:0]           o_TrapCause;
  logic [CNT_WIDTH-1:0] o_CycleCount;
  logic [CNT_WIDTH-1:0] o_StallCount;

  modport master (
    input  i_ID_Valid, i_ID_rs1, i_ID_rs2, i_ID_UsesRs1, i_ID_UsesRs2,
           i_ID_EnvCall, i_ID_EnvBreak, i_ID_Illegal,
           i_EX_MemRead, i_EX_rd, i_EX_Redirect,
           i_MEM_Req, i_MEM_Ready, i_Resume,
    output o_PC_Enable, o_IFID_Enable, o_IDEX_Enable, o_EXMEM_Enable, o_MEMWB_Enable,
           o_IFID_Flush, o_IDEX_Flush, o_Halted, o_TrapCause,
           o_CycleCount, o_StallCount
  );

  modport slave (
    output i_ID_Valid, i_ID_rs1, i_ID_rs2, i_ID_UsesRs1, i_ID_UsesRs2,
           i_ID_EnvCall, i_ID_EnvBreak, i_ID_Illegal,
           i_EX_MemRead, i_EX_rd, i_EX_Redirect,
           i_MEM_Req, i_MEM_Ready, i_Resume,
    input  o_PC_Enable, o_IFID_Enable, o_IDEX_Enable, o_EXMEM_Enable, o_MEMWB_Enable,
           o_IFID_Flush, o_IDEX_Flush, o_Halted, o_TrapCause,
           o_CycleCount, o_StallCount
  );
endinterface

// File: rtl/pipeline_control.sv
// Hazard/sequencing controller for a 5-stage RV32I pipeline: stage enables and flushes,
// RUN/DRAIN/HALTED trap sequencing, data-bus timeout and cycle/stall counters.
module pipeline_control #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  pipeline_control_if.master  bus
);
  localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ECALL   = 3'd1;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [2:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic frozen;
  logic timeout;
  logic id_trap;
  logic load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl;

  always_comb begin
    frozen   = bus.i_MEM_Req && !bus.i_MEM_Ready && (state_q != ST_HALTED);
    // wait_q counts earlier frozen cycles, so this fires on the MEM_TIMEOUT-th one.
    timeout  = frozen && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    id_trap  = bus.i_ID_Valid &&
               (bus.i_ID_EnvCall || bus.i_ID_EnvBreak || bus.i_ID_Illegal);
    load_use = bus.i_ID_Valid && bus.i_EX_MemRead && (bus.i_EX_rd != 5'd0) &&
               ((bus.i_ID_UsesRs1 && (bus.i_ID_rs1 == bus.i_EX_rd)) ||
                (bus.i_ID_UsesRs2 && (bus.i_ID_rs2 == bus.i_EX_rd)));
  end

  // Stage control, before the reset override.
  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    idex_en  = 1'b1;
    exmem_en = 1'b1;
    memwb_en = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    if (state_q == ST_HALTED || frozen) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state_q == ST_DRAIN) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_fl = 1'b1;
    end else if (bus.i_EX_Redirect) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (id_trap) begin
      pc_en   = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (load_use) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_fl = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = '0;
    cause_d = cause_q;
    cycle_d = cycle_q;
    stall_d = stall_q;

    if (state_q != ST_HALTED) begin
      cycle_d = cycle_q + 1'b1;
      if (!pc_en) begin
        stall_d = stall_q + 1'b1;
      end
    end

    if (state_q == ST_HALTED) begin
      if (bus.i_Resume) begin
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
    end else if (frozen) begin
      if (timeout) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else if (state_q == ST_DRAIN) begin
      if (drain_q == DRAIN_W'(1)) begin
        state_d = ST_HALTED;
      end else begin
        drain_d = drain_q - 1'b1;
      end
    end else if (!bus.i_EX_Redirect && id_trap) begin
      state_d = ST_DRAIN;
      drain_d = DRAIN_W'(DRAIN_CYCLES);
      if (bus.i_ID_Illegal) begin
        cause_d = CAUSE_ILLEGAL;
      end else if (bus.i_ID_EnvBreak) begin
        cause_d = CAUSE_EBREAK;
      end else begin
        cause_d = CAUSE_ECALL;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  // While reset is held every stage loads a bubble and nothing advances.
  assign bus.o_PC_Enable    = i_Reset_n && pc_en;
  assign bus.o_IFID_Enable  = i_Reset_n && ifid_en;
  assign bus.o_IDEX_Enable  = i_Reset_n && idex_en;
  assign bus.o_EXMEM_Enable = i_Reset_n && exmem_en;
  assign bus.o_MEMWB_Enable = i_Reset_n && memwb_en;
  assign bus.o_IFID_Flush   = !i_Reset_n || ifid_fl;
  assign bus.o_IDEX_Flush   = !i_Reset_n || idex_fl;
  assign bus.o_Halted       = (state_q == ST_HALTED);
  assign bus.o_TrapCause    = cause_q;
  assign bus.o_CycleCount   = cycle_q;
  assign bus.o_StallCount   = stall_q;
endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed scenarios then random traffic,
// expected outputs come from a behavioural model of the controller rules.
module tb_pipeline_control;
  localparam int DRAIN  = 3;
  localparam int TMO    = 4;
  localparam int M_RUN  = 0;
  localparam int M_DRN  = 1;
  localparam int M_HLT  = 2;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       ecall;
    logic       ebreak;
    logic       illegal;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       resume;
  } stim_t;

  typedef struct packed {
    logic [4:0]  en;     // {PC, IFID, IDEX, EXMEM, MEMWB}
    logic [1:0]  fl;     // {IFID, IDEX}
    logic        halted;
    logic [2:0]  cause;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;
  exp_t exp_q[$];

  int          m_state;
  int          m_drain_left;
  int          m_frozen_run;
  int          m_cause;
  logic [31:0] m_cycles;
  logic [31:0] m_stalls;

  pipeline_control_if #(.CNT_WIDTH(32)) bus_if ();

  pipeline_control #(
    .DRAIN_CYCLES(DRAIN),
    .MEM_TIMEOUT (TMO),
    .CNT_WIDTH   (32)
  ) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_reset();
    m_state      = M_RUN;
    m_drain_left = 0;
    m_frozen_run = 0;
    m_cause      = 0;
    m_cycles     = '0;
    m_stalls     = '0;
  endtask

  task automatic apply(input stim_t s);
    bus_if.i_ID_Valid    = s.id_valid;
    bus_if.i_ID_rs1      = s.rs1;
    bus_if.i_ID_rs2      = s.rs2;
    bus_if.i_ID_UsesRs1  = s.use1;
    bus_if.i_ID_UsesRs2  = s.use2;
    bus_if.i_ID_EnvCall  = s.ecall;
    bus_if.i_ID_EnvBreak = s.ebreak;
    bus_if.i_ID_Illegal  = s.illegal;
    bus_if.i_EX_MemRead  = s.ex_memread;
    bus_if.i_EX_rd       = s.ex_rd;
    bus_if.i_EX_Redirect = s.redirect;
    bus_if.i_MEM_Req     = s.mem_req;
    bus_if.i_MEM_Ready   = s.mem_ready;
    bus_if.i_Resume      = s.resume;
  endtask

  // One cycle: drive, predict, queue the prediction, advance the model, wait for the edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit   stuck, trap, hazard;
    apply(s);
    stuck  = s.mem_req && !s.mem_ready && (m_state != M_HLT);
    trap   = s.id_valid && (s.ecall || s.ebreak || s.illegal);
    hazard = s.id_valid && s.ex_memread && (s.ex_rd != 0) &&
             ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    e.halted = (m_state == M_HLT);
    e.cause  = 3'(m_cause);
    e.cyc    = m_cycles;
    e.stl    = m_stalls;
    if (m_state == M_HLT || stuck) begin
      e.en = 5'b00000; e.fl = 2'b00;
    end else if (m_state == M_DRN) begin
      e.en = 5'b00111; e.fl = 2'b01;
    end else if (s.redirect) begin
      e.en = 5'b11111; e.fl = 2'b11;
    end else if (trap) begin
      e.en = 5'b01111; e.fl = 2'b11;
    end else if (hazard) begin
      e.en = 5'b00111; e.fl = 2'b01;
    end else begin
      e.en = 5'b11111; e.fl = 2'b00;
    end
    exp_q.push_back(e);
    pushed++;

    if (m_state != M_HLT) begin
      m_cycles = m_cycles + 1;
      if (!e.en[4]) m_stalls = m_stalls + 1;
    end
    if (m_state == M_HLT) begin
      if (s.resume) begin
        m_state = M_RUN;
        m_cause = 0;
      end
    end else if (stuck) begin
      m_frozen_run++;
      if (m_frozen_run == TMO) begin
        m_state = M_HLT;
        m_cause = 4;
      end
    end else begin
      m_frozen_run = 0;
      if (m_state == M_DRN) begin
        m_drain_left--;
        if (m_drain_left == 0) m_state = M_HLT;
      end else if (!s.redirect && trap) begin
        m_state      = M_DRN;
        m_drain_left = DRAIN;
        m_cause      = s.illegal ? 3 : (s.ebreak ? 2 : 1);
      end
    end
    if (m_state != M_RUN || stuck) m_frozen_run = stuck ? m_frozen_run : 0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      popped++;
      check("enables", 32'({bus_if.o_PC_Enable, bus_if.o_IFID_Enable, bus_if.o_IDEX_Enable,
                            bus_if.o_EXMEM_Enable, bus_if.o_MEMWB_Enable}), 32'(e.en));
      check("flushes", 32'({bus_if.o_IFID_Flush, bus_if.o_IDEX_Flush}), 32'(e.fl));
      check("halted", 32'(bus_if.o_Halted), 32'(e.halted));
      check("cause", 32'(bus_if.o_TrapCause), 32'(e.cause));
      check("cycle_count", bus_if.o_CycleCount, e.cyc);
      check("stall_count", bus_if.o_StallCount, e.stl);
      $display("cycle t=%0t en=%b fl=%b halted=%0d cause=%0d cyc=%0d stl=%0d", $time,
               e.en, e.fl, e.halted, e.cause, e.cyc, e.stl);
    end
  end

  // Reset is dropped and raised between clock edges; outputs must react without a clock.
  task automatic rst_pulse();
    apply(idle());
    #1 rst_n = 1'b0;
    #1;
    check("rst_enables", 32'({bus_if.o_PC_Enable, bus_if.o_IFID_Enable, bus_if.o_IDEX_Enable,
                              bus_if.o_EXMEM_Enable, bus_if.o_MEMWB_Enable}), 32'd0);
    check("rst_flushes", 32'({bus_if.o_IFID_Flush, bus_if.o_IDEX_Flush}), 32'd3);
    check("rst_halted", 32'(bus_if.o_Halted), 32'd0);
    check("rst_cause", 32'(bus_if.o_TrapCause), 32'd0);
    check("rst_cycle", bus_if.o_CycleCount, 32'd0);
    check("rst_stall", bus_if.o_StallCount, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_cycle", bus_if.o_CycleCount, 32'd0);
    check("rst_hold_pc_en", 32'(bus_if.o_PC_Enable), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b1;
    apply(idle());
    model_reset();
    #2;
    rst_pulse();

    // Ten RUN cycles containing exactly one load-use stall.
    s = idle(); s.id_valid = 1; s.rs1 = 5; s.use1 = 1; s.ex_memread = 1; s.ex_rd = 5;
    step(s);
    s = idle(); s.id_valid = 1; s.rs1 = 5; s.use1 = 1;
    step(s);
    s = idle(); s.id_valid = 1; s.rs1 = 0; s.use1 = 1; s.ex_memread = 1; s.ex_rd = 0;
    step(s);
    for (int i = 0; i < 7; i++) step(idle());
    check("cycle_after_10", bus_if.o_CycleCount, 32'd10);
    check("stall_after_10", bus_if.o_StallCount, 32'd1);

    // Redirect beats a simultaneous load-use and ECALL.
    s = idle(); s.redirect = 1; s.id_valid = 1; s.ecall = 1; s.rs2 = 7; s.use2 = 1;
    s.ex_memread = 1; s.ex_rd = 7;
    step(s);
    check("redirect_no_trap", 32'({bus_if.o_Halted, bus_if.o_TrapCause}), 32'd0);
    step(idle());

    // ECALL with one freeze cycle in the middle of the drain.
    s = idle(); s.id_valid = 1; s.ecall = 1;
    step(s);
    s = idle(); s.redirect = 1;
    step(s);
    s = idle(); s.mem_req = 1;
    step(s);
    step(idle());
    check("ecall_not_yet_halted", 32'(bus_if.o_Halted), 32'd0);
    step(idle());
    check("ecall_halted", 32'(bus_if.o_Halted), 32'd1);
    check("ecall_cause", 32'(bus_if.o_TrapCause), 32'd1);
    step(idle());
    s = idle(); s.resume = 1;
    step(s);
    check("resume_run", 32'(bus_if.o_Halted), 32'd0);
    check("resume_cause", 32'(bus_if.o_TrapCause), 32'd0);

    // Memory timeout after four frozen cycles.
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < 3; i++) step(s);
    check("timeout_not_yet", 32'(bus_if.o_Halted), 32'd0);
    step(s);
    check("timeout_halted", 32'(bus_if.o_Halted), 32'd1);
    check("timeout_cause", 32'(bus_if.o_TrapCause), 32'd4);
    s = idle(); s.resume = 1;
    step(s);
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < 3; i++) step(s);
    s.mem_ready = 1;
    step(s);
    step(idle());
    check("ready_on_4th_no_trap", 32'(bus_if.o_Halted), 32'd0);

    // ILLEGAL and EBREAK together resolve to ILLEGAL.
    s = idle(); s.id_valid = 1; s.illegal = 1; s.ebreak = 1;
    step(s);
    for (int i = 0; i < DRAIN; i++) step(idle());
    check("illegal_cause", 32'(bus_if.o_TrapCause), 32'd3);
    check("illegal_halted", 32'(bus_if.o_Halted), 32'd1);
    s = idle(); s.resume = 1;
    step(s);

    // Asynchronous reset in the middle of a drain.
    s = idle(); s.id_valid = 1; s.ecall = 1;
    step(s);
    step(idle());
    rst_pulse();

    // Random traffic with occasional bus stalls long enough to time out.
    begin
      int stuck_left = 0;
      for (int n = 0; n < 3000; n++) begin
        s = idle();
        s.id_valid   = ($urandom_range(0, 3) != 0);
        s.rs1        = 5'($urandom_range(0, 3));
        s.rs2        = 5'($urandom_range(0, 3));
        s.use1       = 1'($urandom_range(0, 1));
        s.use2       = 1'($urandom_range(0, 1));
        s.ecall      = ($urandom_range(0, 39) == 0);
        s.ebreak     = ($urandom_range(0, 59) == 0);
        s.illegal    = ($urandom_range(0, 59) == 0);
        s.ex_memread = ($urandom_range(0, 2) == 0);
        s.ex_rd      = 5'($urandom_range(0, 3));
        s.redirect   = ($urandom_range(0, 6) == 0);
        s.resume     = ($urandom_range(0, 3) == 0);
        if (stuck_left == 0 && $urandom_range(0, 39) == 0) stuck_left = $urandom_range(3, 6);
        if (stuck_left > 0) begin
          stuck_left--;
          s.mem_req   = 1;
          s.mem_ready = 0;
        end else begin
          s.mem_req   = ($urandom_range(0, 3) == 0);
          s.mem_ready = 1'($urandom_range(0, 1));
        end
        step(s);
      end
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("push_pop_balance", 32'(popped), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
